// File: rtl/rec_pkg.sv
// Shared definitions for the voice-recorder elapsed-seconds timer:
// mode encoding, time width and the default recording limit.
package rec_pkg;

  localparam int TIME_W      = 6;
  localparam int MAX_SEC_DEF = 32;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REC        = 3'd1,
    PAUSE_REC  = 3'd2,
    PLAY       = 3'd3,
    PAUSE_PLAY = 3'd4
  } state_t;

  // Seconds only advance in the two running modes.
  function automatic logic is_active(state_t s);
    return (s == REC) || (s == PLAY);
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Fractional prescaler producing one-second ticks; the playback speed factor
// scales the accumulator step (fast) or divides the raw tick rate (slow).
module sec_tick_gen #(
  parameter int CLK_HZ = 12_000_000,
  parameter int SPD_W  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_play,
  input  logic             i_fast,
  input  logic [SPD_W-1:0] i_speed,
  output logic             o_tick
);

  localparam int ACC_W = $clog2(CLK_HZ) + SPD_W + 1;
  localparam logic [ACC_W-1:0] HZ = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_sum, step;
  logic [SPD_W-1:0] slow_q, slow_d;
  logic [SPD_W-1:0] spd_q;
  logic             fast_q;
  logic             raw_tick;
  logic             tick;
  logic             scaled;

  assign scaled = i_play && (spd_q != '0);

  // NOTE: every signal assigned here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    step     = ACC_W'(1);
    acc_d    = acc_q;
    slow_d   = slow_q;
    tick     = 1'b0;
    if (scaled && fast_q) step = ACC_W'(spd_q) + ACC_W'(1);
    acc_sum  = acc_q + step;
    raw_tick = (acc_sum >= HZ);

    if (i_clr) begin
      acc_d  = '0;
      slow_d = '0;
    end else if (i_en) begin
      // Keep the remainder on wrap so long sessions do not drift.
      acc_d = raw_tick ? (acc_sum - HZ) : acc_sum;
      if (scaled && !fast_q) begin
        if (raw_tick) begin
          if (slow_q == spd_q) begin
            tick   = 1'b1;
            slow_d = '0;
          end else begin
            slow_d = slow_q + SPD_W'(1);
          end
        end
      end else begin
        tick = raw_tick;
      end
    end
  end

  assign o_tick = tick;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q  <= '0;
      slow_q <= '0;
      spd_q  <= '0;
      fast_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      slow_q <= slow_d;
      if (i_load) begin
        fast_q <= i_fast;
        spd_q  <= i_speed;
      end
    end
  end

endmodule

// File: rtl/rec_sec_timer.sv
// Recorder mode FSM and elapsed-seconds counter; drives the two-digit display
// time, the latched recording length and the automatic-end pulse.
module rec_sec_timer
  import rec_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int MAX_SEC = MAX_SEC_DEF,
  parameter int SPD_W   = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start_rec,
  input  logic              i_start_play,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_fast,
  input  logic [SPD_W-1:0]  i_speed,
  output logic [TIME_W-1:0] o_time,
  output logic [TIME_W-1:0] o_rec_len,
  output logic [2:0]        o_state,
  output logic              o_recording,
  output logic              o_playing,
  output logic              o_done
);

  localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_SEC);

  state_t            state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [TIME_W-1:0] len_q, len_d;
  logic [TIME_W-1:0] time_inc;
  logic              done_q, done_d;
  logic              rec_q, play_q;
  logic              clr, load, tick;

  sec_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .SPD_W  (SPD_W)
  ) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (is_active(state_q)),
    .i_clr   (clr),
    .i_load  (load),
    .i_play  (state_q == PLAY),
    .i_fast  (i_fast),
    .i_speed (i_speed),
    .o_tick  (tick)
  );

  assign time_inc = time_q + TIME_W'(1);

  // Commands ignored in a given mode do not block lower-priority ones.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    len_d   = len_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start_rec) begin
          state_d = REC;
          time_d  = '0;
          clr     = 1'b1;
        end else if (i_start_play && (len_q != '0)) begin
          state_d = PLAY;
          time_d  = '0;
          clr     = 1'b1;
          load    = 1'b1;
        end
      end
      REC: begin
        if (i_stop) begin
          state_d = IDLE;
          len_d   = time_q;
        end else if (i_pause) begin
          state_d = PAUSE_REC;
        end else if (tick) begin
          time_d = time_inc;
          if (time_inc == MAX_T) begin
            state_d = IDLE;
            len_d   = MAX_T;
            done_d  = 1'b1;
          end
        end
      end
      PLAY: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (i_pause) begin
          state_d = PAUSE_PLAY;
        end else if (tick) begin
          time_d = time_inc;
          if (time_inc == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      PAUSE_REC: begin
        if (i_stop) begin
          state_d = IDLE;
          len_d   = time_q;
        end else if (i_pause || i_start_rec) begin
          state_d = REC;
        end
      end
      PAUSE_PLAY: begin
        if (i_stop) begin
          state_d = IDLE;
        end else if (i_pause || i_start_play) begin
          state_d = PLAY;
          load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      time_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      rec_q   <= 1'b0;
      play_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      len_q   <= len_d;
      done_q  <= done_d;
      rec_q   <= (state_d == REC)  || (state_d == PAUSE_REC);
      play_q  <= (state_d == PLAY) || (state_d == PAUSE_PLAY);
    end
  end

  assign o_time      = time_q;
  assign o_rec_len   = len_q;
  assign o_state     = state_q;
  assign o_recording = rec_q;
  assign o_playing   = play_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_rec_sec_timer.sv
// Randomized and directed bench for rec_sec_timer: a session-level model queues
// the expected outputs per cycle and an independent monitor compares them.
module tb_rec_sec_timer;
  import rec_pkg::*;

  localparam int CLK_HZ  = 10;
  localparam int MAX_SEC = 32;
  localparam int SPD_W   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_rec = 1'b0, start_play = 1'b0, pause = 1'b0, stop = 1'b0;
  logic             fast = 1'b0;
  logic [SPD_W-1:0] speed = '0;
  logic [5:0]       o_time, o_rec_len;
  logic [2:0]       o_state;
  logic             o_recording, o_playing, o_done;

  always #5 clk = ~clk;

  rec_sec_timer #(.CLK_HZ(CLK_HZ), .MAX_SEC(MAX_SEC), .SPD_W(SPD_W)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start_rec  (start_rec),
    .i_start_play (start_play),
    .i_pause      (pause),
    .i_stop       (stop),
    .i_fast       (fast),
    .i_speed      (speed),
    .o_time       (o_time),
    .o_rec_len    (o_rec_len),
    .o_state      (o_state),
    .o_recording  (o_recording),
    .o_playing    (o_playing),
    .o_done       (o_done)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] tm;
    logic [5:0] len;
    logic       rec;
    logic       play;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Session model: progress counts accumulated steps since the session began;
  // a raw second elapses whenever progress crosses a multiple of CLK_HZ.
  state_t     m_state;
  int         m_time, m_len, m_slow, m_spd;
  bit         m_fast, m_done;
  longint     m_prog;
  bit         fast_v = 1'b0;
  int         speed_v = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE;
    m_time  = 0;
    m_len   = 0;
    m_slow  = 0;
    m_spd   = 0;
    m_fast  = 0;
    m_done  = 0;
    m_prog  = 0;
  endtask

  task automatic model_step(input bit sr, input bit sp, input bit pa, input bit st);
    bit tick;
    bit raw;
    int step;
    tick   = 0;
    m_done = 0;
    if (m_state == REC || m_state == PLAY) begin
      step   = (m_state == PLAY && m_fast && m_spd != 0) ? m_spd + 1 : 1;
      raw    = ((m_prog + step) / CLK_HZ) != (m_prog / CLK_HZ);
      m_prog = m_prog + step;
      if (m_state == PLAY && !m_fast && m_spd != 0) begin
        if (raw) begin
          if (m_slow == m_spd) begin
            tick   = 1;
            m_slow = 0;
          end else begin
            m_slow++;
          end
        end
      end else begin
        tick = raw;
      end
    end
    case (m_state)
      IDLE: begin
        if (sr) begin
          m_state = REC; m_time = 0; m_prog = 0; m_slow = 0;
        end else if (sp && m_len != 0) begin
          m_state = PLAY; m_time = 0; m_prog = 0; m_slow = 0;
          m_fast = fast_v; m_spd = speed_v;
        end
      end
      REC: begin
        if (st) begin
          m_state = IDLE; m_len = m_time;
        end else if (pa) begin
          m_state = PAUSE_REC;
        end else if (tick) begin
          m_time++;
          if (m_time == MAX_SEC) begin
            m_state = IDLE; m_len = MAX_SEC; m_done = 1;
          end
        end
      end
      PLAY: begin
        if (st) m_state = IDLE;
        else if (pa) m_state = PAUSE_PLAY;
        else if (tick) begin
          m_time++;
          if (m_time == m_len) begin
            m_state = IDLE; m_done = 1;
          end
        end
      end
      PAUSE_REC: begin
        if (st) begin
          m_state = IDLE; m_len = m_time;
        end else if (pa || sr) m_state = REC;
      end
      PAUSE_PLAY: begin
        if (st) m_state = IDLE;
        else if (pa || sp) begin
          m_state = PLAY; m_fast = fast_v; m_spd = speed_v;
        end
      end
      default: m_state = IDLE;
    endcase
  endtask

  // One clock cycle of stimulus; inputs change on the falling edge.
  task automatic cyc(input bit sr, input bit sp, input bit pa, input bit st);
    exp_t e;
    @(negedge clk);
    start_rec  = sr;
    start_play = sp;
    pause      = pa;
    stop       = st;
    fast       = fast_v;
    speed      = SPD_W'(speed_v);
    model_step(sr, sp, pa, st);
    e.st   = 3'(int'(m_state));
    e.tm   = 6'(m_time);
    e.len  = 6'(m_len);
    e.rec  = (m_state == REC)  || (m_state == PAUSE_REC);
    e.play = (m_state == PLAY) || (m_state == PAUSE_PLAY);
    e.done = m_done;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(o_state), 0);
    check({tag, "_time"}, 32'(o_time), 0);
    check({tag, "_rec_len"}, 32'(o_rec_len), 0);
    check({tag, "_recording"}, 32'(o_recording), 0);
    check({tag, "_playing"}, 32'(o_playing), 0);
    check({tag, "_done"}, 32'(o_done), 0);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state", 32'(o_state), 32'(e.st));
        check("time", 32'(o_time), 32'(e.tm));
        check("rec_len", 32'(o_rec_len), 32'(e.len));
        check("recording", 32'(o_recording), 32'(e.rec));
        check("playing", 32'(o_playing), 32'(e.play));
        check("done", 32'(o_done), 32'(e.done));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Play with nothing recorded is ignored.
    cyc(0, 1, 0, 0); idle(3);

    // Record 3 s: start at edge 0, stop at edge 35.
    cyc(1, 0, 0, 0); idle(34); cyc(0, 0, 0, 1); idle(3);

    // Fast playback x2, then slow playback /2, each to automatic end.
    fast_v = 1; speed_v = 1;
    cyc(0, 1, 0, 0); idle(20);
    fast_v = 0; speed_v = 1;
    cyc(0, 1, 0, 0); idle(70);

    // Record to the limit.
    fast_v = 0; speed_v = 0;
    cyc(1, 0, 0, 0); idle(330);

    // Pause after 15 record cycles, hold 50, resume.
    cyc(1, 0, 0, 0); idle(14); cyc(0, 0, 1, 0); idle(50);
    cyc(0, 0, 1, 0); idle(20); cyc(0, 0, 0, 1); idle(2);

    // Stop coinciding with the first tick: time stays 0, length becomes 0.
    cyc(1, 0, 0, 0); idle(9); cyc(0, 0, 0, 1); idle(2);
    cyc(0, 1, 0, 0); idle(2);

    // Simultaneous start_rec and start_play from IDLE records.
    cyc(1, 1, 0, 0); idle(25); cyc(0, 0, 0, 1); idle(2);

    // Mid-play speed change only applies after pause/resume.
    fast_v = 1; speed_v = 3;
    cyc(0, 1, 0, 0); idle(6);
    fast_v = 0; speed_v = 2; idle(4);
    cyc(0, 0, 1, 0); idle(3); cyc(0, 1, 0, 0); idle(40);

    // Randomized command stream.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        fast_v  = 1'($urandom_range(0, 1));
        speed_v = $urandom_range(0, 7);
      end
      r = $urandom_range(0, 199);
      cyc(r < 2, r >= 2 && r < 5, r >= 5 && r < 7, r >= 7 && r < 9);
    end
    cyc(0, 0, 0, 1); idle(2);

    // Asynchronous reset in the middle of playback.
    fast_v = 0; speed_v = 0;
    cyc(1, 0, 0, 0); idle(30); cyc(0, 0, 0, 1); idle(1);
    cyc(0, 1, 0, 0); idle(12);
    @(posedge clk);
    #3;
    check("pre_reset_playing", 32'(o_playing), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 0, 0); idle(3);

    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rec_sec_timer.md
Name: rec_sec_timer

Overview:
- Elapsed-seconds timer for the voice recorder's record and playback sessions.
- Tracks recorder mode (idle/record/play/pause) from single-cycle key-command pulses.
- Produces o_time (0..32), which feeds the two-digit seven-segment decoder directly, plus the latched recording length.
- Playback seconds advance at the selected fast/slow speed, so the display tracks audio position, not wall time.

Parameters:
- CLK_HZ, 12_000_000: i_clk cycles per real-time second.
- MAX_SEC, 32: maximum recording length in seconds. Must be ≤ 63.
- SPD_W, 3: width of the speed-factor input.

Ports:
- i_clk, input, 1: system clock.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_start_rec, input, 1: start-record pulse; resumes a paused record.
- i_start_play, input, 1: start-play pulse; resumes a paused play.
- i_pause, input, 1: pause/resume toggle pulse.
- i_stop, input, 1: stop pulse.
- i_fast, input, 1: 1 = fast playback, 0 = slow playback (only meaningful when i_speed ≠ 0).
- i_speed, input, SPD_W: speed factor s; 0 = normal, otherwise ×(s+1) or ÷(s+1).
- o_time, output, 6: current elapsed seconds, 0..MAX_SEC.
- o_rec_len, output, 6: length of the last completed recording.
- o_state, output, 3: state encoding from the shared package.
- o_recording, output, 1: 1 in REC or PAUSE_REC.
- o_playing, output, 1: 1 in PLAY or PAUSE_PLAY.
- o_done, output, 1: one-cycle pulse on automatic end (record full or play end).

Behaviour:
- Reset (i_rst_n low, async): state IDLE; o_time = 0, o_rec_len = 0, o_done = 0; prescaler, slow counter and latched speed cleared. Reset mid-session abandons the session and keeps nothing.
- All outputs are registered. o_recording and o_playing are decoded from the state register.
- Command priority within a cycle: i_stop > i_pause > i_start_rec > i_start_play.
- State transitions:
  - IDLE:
    - start_rec → REC; o_time ← 0.
    - start_play with o_rec_len ≠ 0 → PLAY; o_time ← 0.
    - start_play with o_rec_len = 0 is ignored.
    - stop and pause are ignored.
  - REC:
    - stop → IDLE; o_rec_len ← o_time.
    - pause → PAUSE_REC.
    - tick → o_time + 1. If the new value = MAX_SEC: → IDLE, o_rec_len ← MAX_SEC, o_done = 1 next cycle.
  - PLAY:
    - stop → IDLE.
    - pause → PAUSE_PLAY.
    - tick → o_time + 1. If the new value = o_rec_len: → IDLE, o_done pulse.
  - PAUSE_REC:
    - pause or start_rec → REC.
    - stop → IDLE; o_rec_len ← o_time.
    - start_play is ignored.
  - PAUSE_PLAY:
    - pause or start_play → PLAY.
    - stop → IDLE.
    - start_rec is ignored.
- o_time holds its last value in IDLE until the next start.
- Prescaler and tick generation:
  - Accumulator acc, width clog2(CLK_HZ)+SPD_W+1.
  - The accumulator is cleared on every entry to REC or PLAY from IDLE.
  - In the paused states it holds its value, and no ticks are produced.
  - In IDLE no ticks are produced.
- Step rules:
  - REC: step = 1.
  - PLAY, fast: step = s+1.
  - PLAY, slow or s = 0: step = 1.
  - Each active cycle: if acc + step ≥ CLK_HZ, then acc ← acc + step − CLK_HZ and a raw tick fires; otherwise acc ← acc + step. The remainder carries over, so there is no drift.
  - PLAY, slow, s ≠ 0: raw ticks go to slow_cnt. A tick fires when slow_cnt = s, and slow_cnt then returns to 0.
- Speed latching: {i_fast, i_speed} is latched on entry to PLAY and on resume. Mid-play changes take effect only after pause/resume or restart.
- Tick coinciding with stop or pause: the command wins and the tick is discarded. The acc wrap still applies.
- Latency: o_time updates the cycle after the tick condition. A command changes state the cycle after the pulse.
- o_done never asserts on a manual stop.

Decomposition:
- Package rec_pkg:
  - state_t enum: IDLE = 0, REC = 1, PAUSE_REC = 2, PLAY = 3, PAUSE_PLAY = 4.
  - localparam TIME_W = 6.
  - Default MAX_SEC.
- Sub-module sec_tick_gen contains the accumulator, slow counter and speed latch.
  - Inputs: i_en, i_clr, i_load, i_fast, i_speed.
  - Output: o_tick.
- rec_sec_timer holds the FSM, o_time, o_rec_len and o_done.

Test Plan (CLK_HZ = 10, MAX_SEC = 32):
- Record 3 s: start_rec at cycle 0, stop at cycle 35 → o_time steps at 10/20/30 to 3; o_rec_len = 3; no o_done.
- Record full: start_rec, run 330 cycles → o_time reaches 32 at cycle 320; state IDLE; o_rec_len = 32; o_done high for exactly 1 cycle.
- Play fast: o_rec_len = 3, i_fast = 1, i_speed = 1, start_play → ticks every 5 cycles; at o_time = 3 → IDLE with o_done pulse. Play slow with s = 1 → ticks every 20 cycles.
- Pause/resume: REC for 15 cycles, pause for 50, resume → next tick 5 cycles after resume (acc held); o_time = 1 then 2.
- Edge cases:
  - start_play with o_rec_len = 0 → stays IDLE.
  - stop and tick in the same cycle → o_time unchanged.
  - start_rec and start_play together in IDLE → REC.
- Async reset asserted mid-PLAY between clock edges → all outputs 0 and IDLE immediately; o_rec_len cleared.
